// File: rtl/neuron_layer_if.sv
// Handshake and data bundle between a layer engine and its producer/consumer.
interface neuron_layer_if #(
  parameter int N  = 10,
  parameter int M  = 4,
  parameter int DW = 8,
  parameter int BW = 16,
  parameter int OW = 8
);
  logic              start;
  logic              act_mode;
  logic [N*DW-1:0]   in_vec;
  logic [M*N*DW-1:0] w_vec;
  logic [M*BW-1:0]   bias_vec;
  logic [M*OW-1:0]   out_vec;
  logic              ready;
  logic              done;

  modport master (
    output start, act_mode, in_vec, w_vec, bias_vec,
    input  out_vec, ready, done
  );

  modport slave (
    input  start, act_mode, in_vec, w_vec, bias_vec,
    output out_vec, ready, done
  );
endinterface

// File: rtl/neuron_layer.sv
// Fully-connected layer: M neurons each run one MAC per cycle over N inputs,
// then shift, optional ReLU and saturation to OW bits.
module neuron_layer #(
  parameter int N     = 10,
  parameter int M     = 4,
  parameter int DW    = 8,
  parameter int BW    = 16,
  parameter int OW    = 8,
  parameter int SHIFT = 0,
  parameter int ACC_W = 2*DW + $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  neuron_layer_if.slave bus
);
  localparam int KW = $clog2(N);
  localparam logic signed [ACC_W-1:0] P_MAX = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] P_MIN = ~P_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT} state_t;

  state_t                  r_state;
  logic [KW-1:0]           r_k;
  logic                    r_mode;
  logic signed [DW-1:0]    r_x [N];
  logic signed [DW-1:0]    r_w [M][N];
  logic signed [ACC_W-1:0] r_acc [M];
  logic [M*OW-1:0]         r_out;
  logic                    r_ready;
  logic                    r_done;

  logic signed [2*DW-1:0]  w_prod [M];
  logic signed [ACC_W-1:0] w_s [M];
  logic [M*OW-1:0]         w_res;

  always_comb begin
    for (int unsigned j = 0; j < M; j++) begin
      w_prod[j] = r_x[r_k] * r_w[j][r_k];
    end
  end

  // Shift, ReLU and clamp are evaluated continuously but only latched on the ACT edge.
  always_comb begin
    w_res = '0;
    for (int unsigned j = 0; j < M; j++) begin
      w_s[j] = r_acc[j] >>> SHIFT;
      if (!r_mode && w_s[j][ACC_W-1]) w_s[j] = '0;
      if (w_s[j] > P_MAX)      w_s[j] = P_MAX;
      else if (w_s[j] < P_MIN) w_s[j] = P_MIN;
      w_res[j*OW +: OW] = w_s[j][OW-1:0];
    end
  end

  // Operand capture needs no reset: it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      for (int unsigned k = 0; k < N; k++) begin
        r_x[k] <= bus.in_vec[k*DW +: DW];
        for (int unsigned j = 0; j < M; j++) begin
          r_w[j][k] <= bus.w_vec[(j*N+k)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_mode  <= 1'b0;
      r_out   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      for (int unsigned j = 0; j < M; j++) r_acc[j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode  <= bus.act_mode;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_state <= S_MAC;
            for (int unsigned j = 0; j < M; j++) begin
              r_acc[j] <= $signed({{(ACC_W-BW){bus.bias_vec[j*BW+BW-1]}},
                                   bus.bias_vec[j*BW +: BW]});
            end
          end
        end
        S_MAC: begin
          for (int unsigned j = 0; j < M; j++) begin
            r_acc[j] <= r_acc[j] + $signed({{(ACC_W-2*DW){w_prod[j][2*DW-1]}}, w_prod[j]});
          end
          if (r_k == KW'(N-1)) r_state <= S_ACT;
          else                 r_k     <= r_k + 1'b1;
        end
        S_ACT: begin
          r_out   <= w_res;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_vec = r_out;
  assign bus.ready   = r_ready;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_neuron_layer.sv
// Directed bench for neuron_layer: two instances (SHIFT=0 and SHIFT=4) share stimulus.
module tb_neuron_layer;
  localparam int N = 10, M = 4, DW = 8, BW = 16, OW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_layer_if #(.N(N), .M(M), .DW(DW), .BW(BW), .OW(OW)) bus0 ();
  neuron_layer_if #(.N(N), .M(M), .DW(DW), .BW(BW), .OW(OW)) bus1 ();

  neuron_layer #(.N(N), .M(M), .DW(DW), .BW(BW), .OW(OW), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  neuron_layer #(.N(N), .M(M), .DW(DW), .BW(BW), .OW(OW), .SHIFT(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  int ndone0 = 0;
  int ndone1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [M*OW-1:0] out;
    int unsigned     acc_cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic signed [DW-1:0] xv [N];
  logic signed [DW-1:0] wv [M][N];
  logic signed [BW-1:0] bv [M];
  logic                 mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [M*OW-1:0] model(input int sh);
    logic [M*OW-1:0] r;
    longint s, hi, lo;
    hi = (longint'(1) <<< (OW-1)) - 1;
    lo = -hi - 1;
    r = '0;
    for (int j = 0; j < M; j++) begin
      s = longint'(bv[j]);
      for (int k = 0; k < N; k++) s += longint'(xv[k]) * longint'(wv[j][k]);
      s = s >>> sh;
      if (!mode && s < 0) s = 0;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      r[j*OW +: OW] = s[OW-1:0];
    end
    return r;
  endfunction

  task automatic fill(input int x, input int w0, input int w1, input int w2, input int w3,
                      input int b0, input int b1, input int b2, input int b3, input logic md);
    for (int k = 0; k < N; k++) begin
      xv[k] = DW'(x);
      wv[0][k] = DW'(w0);
      wv[1][k] = DW'(w1);
      wv[2][k] = DW'(w2);
      wv[3][k] = DW'(w3);
    end
    bv[0] = BW'(b0); bv[1] = BW'(b1); bv[2] = BW'(b2); bv[3] = BW'(b3);
    mode = md;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) begin
      xv[k] = DW'($urandom_range(0, 40)) - DW'(20);
      for (int j = 0; j < M; j++) wv[j][k] = DW'($urandom);
    end
    for (int j = 0; j < M; j++) bv[j] = BW'($urandom_range(0, 2000)) - BW'(1000);
    mode = 1'($urandom);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus0.in_vec[k*DW +: DW] = xv[k];
      bus1.in_vec[k*DW +: DW] = xv[k];
      for (int j = 0; j < M; j++) begin
        bus0.w_vec[(j*N+k)*DW +: DW] = wv[j][k];
        bus1.w_vec[(j*N+k)*DW +: DW] = wv[j][k];
      end
    end
    for (int j = 0; j < M; j++) begin
      bus0.bias_vec[j*BW +: BW] = bv[j];
      bus1.bias_vec[j*BW +: BW] = bv[j];
    end
    bus0.act_mode = mode;
    bus1.act_mode = mode;
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic start_op(input bit push, input bit hold);
    int n;
    n = 0;
    drive();
    while (!(bus0.ready && bus1.ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait_expired", 64'(n >= 50), 64'(0));
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (push) begin
      q0.push_back('{model(0), cyc});
      q1.push_back('{model(4), cyc});
    end
    @(negedge clk);
    if (!hold) begin
      bus0.start = 1'b0;
      bus1.start = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(q0.size() + q1.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus0.done) begin
      ndone0++;
      chk("done0_ready", 64'(bus0.ready), 64'(1));
      total++;
      assert (q0.size() != 0) else begin
        bad++;
        $error("FAIL done0_unexpected observed=done expected=no_done");
      end
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("out0", 64'(bus0.out_vec), 64'(e.out));
        chk("latency0", 64'(cyc - e.acc_cyc), 64'(N + 1));
      end
    end
    if (bus1.done) begin
      ndone1++;
      total++;
      assert (q1.size() != 0) else begin
        bad++;
        $error("FAIL done1_unexpected observed=done expected=no_done");
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("out1", 64'(bus1.out_vec), 64'(e.out));
        chk("latency1", 64'(cyc - e.acc_cyc), 64'(N + 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int d0, d1;
    int unsigned a1, a2;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    fill(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    drive();

    // Reset held for two edges, then released.
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out0", 64'(bus0.out_vec), 64'(0));
    chk("rst_ready0", 64'(bus0.ready), 64'(1));
    chk("rst_done0", 64'(bus0.done), 64'(0));
    chk("rst_out1", 64'(bus1.out_vec), 64'(0));
    rst = 1'b1;
    d0 = ndone0;
    repeat (20) @(negedge clk);
    chk("idle_no_done", 64'(ndone0), 64'(d0));

    // Basic MAC: expected {64, 20, 5, -20} on the SHIFT=0 instance.
    fill(2, 3, 1, 0, -1, 4, 0, 5, 0, 1'b1);
    start_op(1, 0);
    drain();
    chk("basic_literal", 64'(bus0.out_vec), 64'({8'hEC, 8'd5, 8'd20, 8'd64}));

    // ReLU / identity on a negative sum (-56), then both clamps.
    fill(2, -3, 0, 0, 0, 4, 0, 0, 0, 1'b0);
    start_op(1, 0);
    drain();
    chk("relu_zero", 64'(bus0.out_vec[7:0]), 64'(0));
    fill(2, -3, 0, 0, 0, 4, 0, 0, 0, 1'b1);
    start_op(1, 0);
    drain();
    chk("ident_neg56", 64'(bus0.out_vec[7:0]), 64'(8'hC8));
    fill(127, 127, 127, 127, 127, 0, 0, 0, 0, 1'b1);
    start_op(1, 0);
    drain();
    fill(127, -128, -128, -128, -128, 0, 0, 0, 0, 1'b1);
    start_op(1, 0);
    drain();
    chk("neg_clamp", 64'(bus0.out_vec[7:0]), 64'(8'h80));

    // Shift: acc=1000, SHIFT=4 gives 62.
    fill(10, 10, 10, 10, 10, 0, 0, 0, 0, 1'b1);
    start_op(1, 0);
    drain();
    chk("shift_62", 64'(bus1.out_vec[7:0]), 64'(62));

    // Start pulse mid-MAC with different operands is ignored.
    fill(3, 5, -7, 2, 1, 10, -10, 100, -3, 1'b1);
    start_op(1, 0);
    repeat (4) @(negedge clk);
    fill(-9, 9, 9, 9, 9, 1, 1, 1, 1, 1'b0);
    drive();
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    drain();

    // Start held through done: second accept lands on the done cycle.
    fill_rand();
    start_op(1, 1);
    a1 = last_acc;
    fill_rand();
    start_op(1, 0);
    a2 = last_acc;
    chk("b2b_spacing", 64'(a2 - a1), 64'(N + 2));
    drain();

    // Operands changed one cycle after accept do not affect the result.
    fill_rand();
    start_op(1, 0);
    fill_rand();
    drive();
    drain();

    // Reset on the 5th MAC edge aborts without a done pulse.
    fill(4, 4, 4, 4, 4, 1, 2, 3, 4, 1'b1);
    start_op(0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_out0", 64'(bus0.out_vec), 64'(0));
    chk("abort_ready0", 64'(bus0.ready), 64'(1));
    chk("abort_done0", 64'(bus0.done), 64'(0));
    d0 = ndone0;
    d1 = ndone1;
    repeat (15) @(negedge clk);
    chk("abort_no_done0", 64'(ndone0), 64'(d0));
    chk("abort_no_done1", 64'(ndone1), 64'(d1));

    // Fresh operations after the abort.
    fill(2, 3, 1, 0, -1, 4, 0, 5, 0, 1'b1);
    start_op(1, 0);
    drain();
    for (int i = 0; i < 4; i++) begin
      fill_rand();
      start_op(1, 0);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neuron_layer.md
# neuron_layer

Parametrised fully-connected layer engine. It evaluates M neurons in parallel over an N-element signed input vector. Each neuron runs one multiply-accumulate per cycle, starting from a per-neuron bias. The block then applies a selectable activation and saturates each result to OW bits. It sits between the input/weight storage and the next layer of the MNIST inference pipeline, and replaces per-neuron instantiation with a single layer-level unit that has start/ready/done handshaking.

## Interface
- N, 10, inputs per neuron (≥2)
- M, 4, neurons per layer (≥1)
- DW, 8, signed input/weight width
- BW, 16, signed bias width
- OW, 8, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- ACC_W, 2*DW+clog2(N)+1, accumulator width (must be ≥ BW+1)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request evaluation; accepted only when ready=1
- act_mode  in  1  0 = ReLU, 1 = identity; sampled at accept
- in_vec  in  N*DW  element k at bits [k*DW +: DW], signed
- w_vec  in  M*N*DW  weight (j,k) at bits [(j*N+k)*DW +: DW], signed
- bias_vec  in  M*BW  bias j at bits [j*BW +: BW], signed
- out_vec  out  M*OW  result j at bits [j*OW +: OW], signed, registered
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse when out_vec updates

## Operation
- States: IDLE, MAC, ACT.
- IDLE with start=1 (accept edge):
  - capture in_vec, w_vec, act_mode into internal registers; inputs may change afterwards;
  - acc[j] ← sign-extended bias[j];
  - k ← 0; go to MAC; ready=0.
- IDLE with start=0: hold.
- MAC: each edge, acc[j] ← acc[j] + x[k]*w[j][k], full-precision signed.
  - k increments; when k=N-1, go to ACT.
  - k counter width is clog2(N); no wrap beyond N-1.
- ACT, one edge, for each j:
  - s = acc[j] >>> SHIFT (arithmetic);
  - if act_mode=0 and s<0, then s=0;
  - clamp s to [-2^(OW-1), 2^(OW-1)-1];
  - out_vec[j] ← s; done=1; go to IDLE.
- start while ready=0 is ignored: no queuing, no effect on the running computation.
- out_vec holds its last value until the next ACT edge. It never shows partial sums.
- No accumulator overflow is possible with ACC_W at its default.

## Timing
- Reset (rst=0 at an edge), in any state: state IDLE, out_vec=0, ready=1, done=0, acc=0, k=0.
- Reset during MAC or ACT aborts the computation. No done pulse follows, and out_vec reads 0.
- Accept at edge T:
  - MAC edges T+1 … T+N;
  - ACT edge T+N+1;
  - done=1 and new out_vec valid during the cycle after T+N+1; ready=1 in the same cycle.
- Latency from accept to done is N+1 cycles.
- start=1 in the done cycle is accepted (back-to-back), giving a throughput of one vector per N+2 cycles.
- done is high for exactly one cycle per accepted start.
- ready drops on the edge that accepts start and returns on the ACT edge.

## Test plan
- Reset, defaults:
  - hold rst=0 for 2 cycles, then release → out_vec=0, ready=1, done=0;
  - start=0 for 20 cycles → no done.
- Basic MAC, defaults:
  - stimulus: x all 2; w[0] all 3; w[1] all 1; w[2] all 0; w[3] all -1; bias {4,0,5,0}; act_mode=1;
  - expected: done exactly 11 cycles after accept; out_vec = {64, 20, 5, -20}.
- ReLU and saturation:
  - ReLU: w[0] all -3, x all 2, bias 4, act_mode=0 → out 0; same with act_mode=1 → -56 (0xC8);
  - positive clamp: x all 127, w all 127 → 127;
  - negative clamp: x all 127, w all -128, act_mode=1 → -128.
- Shift, with SHIFT=4:
  - stimulus: x all 10, w all 10, bias 0;
  - expected: acc=1000, out = 62.
- Handshake:
  - pulse start mid-MAC with altered inputs → ignored, results match the first operands;
  - start held high through done → second accept on the done cycle; done pulses every 12 cycles;
  - inputs changed one cycle after accept → no effect on results.
- Reset mid-operation:
  - assert rst=0 on the 5th MAC cycle → no done; out_vec=0, ready=1;
  - a fresh start afterwards → correct results.
